pipelined_instr_mem: RTL and testbench
======================================

PIPELINED_INSTR_MEM -- requirements
Module: pipelined_instr_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width in bits (multiple of 8, power of 2).
REQ-002 SHALL have parameter MEM_DEPTH, default 1024, number of words (power of 2).
REQ-003 SHALL have parameter LATENCY, default 1, read pipeline depth in cycles (legal range 1..4).
REQ-004 SHALL have ports, in order:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  fetch request can be accepted this cycle.
- req_addr  in  32  byte address of requested word.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response this cycle.
- resp_data  out  DATA_WIDTH  fetched word.
- resp_fault  out  1  request was misaligned or out of range.
- prog_we  in  1  program-load write enable.
- prog_addr  in  32  byte address of word to write.
- prog_data  in  DATA_WIDTH  word to write.
- init_done  out  1  memory clear complete; block in RUN.

Function
REQ-005 SHALL define BSH = log2(DATA_WIDTH/8); word index = req_addr[BSH+log2(MEM_DEPTH)-1 : BSH].
REQ-006 SHALL implement FSM states INIT and RUN; reset low forces INIT with clear counter = 0.
REQ-007 In INIT, SHALL write 0 to word[counter] each cycle, increment counter, and enter RUN in the cycle after word MEM_DEPTH-1 is cleared (exactly MEM_DEPTH cycles in INIT).
REQ-008 init_done SHALL be 1 iff state is RUN.
REQ-009 stall SHALL be 1 when the last pipeline stage holds a valid entry and resp_ready is 0.
REQ-010 req_ready SHALL equal (state == RUN) AND NOT stall, combinationally.
REQ-011 A request SHALL be accepted on a rising edge where req_valid AND req_ready are both 1.
REQ-012 Memory read SHALL be synchronous: an accepted request SHALL read the array at the acceptance edge.
REQ-013 With no stall, resp_valid SHALL assert exactly LATENCY cycles after the acceptance cycle, carrying that request's data.
REQ-014 During stall, all pipeline stages SHALL hold; resp_valid/resp_data/resp_fault SHALL remain stable until resp_ready is 1.
REQ-015 Responses SHALL be returned in acceptance order, with no loss or duplication; back-to-back acceptance SHALL sustain one response per cycle when resp_ready is held 1.
REQ-016 A response SHALL be consumed on an edge where resp_valid AND resp_ready are both 1; with no new entry behind it, resp_valid SHALL drop on the next cycle.
REQ-017 Fault SHALL be flagged when req_addr[BSH-1:0] != 0 or req_addr >= MEM_DEPTH*(DATA_WIDTH/8); a faulting response SHALL have resp_fault = 1 and resp_data = 0; no array access is implied.
REQ-018 A prog_we write in RUN SHALL write prog_data to word index of prog_addr at that edge; misaligned or out-of-range prog writes SHALL be dropped silently.
REQ-019 prog_we SHALL be ignored in INIT.
REQ-020 A read accepted in the same cycle as a prog write to the same word SHALL return the old data (read-before-write); later reads SHALL return the new data.
REQ-021 The program-load port SHALL never stall and SHALL be independent of the fetch handshake.

Reset
REQ-022 While reset is 0: resp_valid = 0, resp_fault = 0, resp_data = 0, req_ready = 0, init_done = 0, all pipeline valid bits cleared.
REQ-023 Reset asserted mid-INIT or mid-RUN SHALL discard in-flight requests (no response issued) and restart INIT from counter 0, re-clearing the whole array.
REQ-024 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-025 Release reset, hold req_valid=1 -> req_ready=0 for exactly 1024 cycles, then init_done=1 and req_ready=1; a read of addr 0x0 returns 0x00000000 with resp_fault=0.
REQ-026 Program write 0x00500093 at 0x4, then read 0x4 with LATENCY=1 and LATENCY=3 -> resp_data=0x00500093, resp_valid 1 and 3 cycles after acceptance respectively.
REQ-027 Read addr 0x6 and addr 0x1000 -> resp_fault=1, resp_data=0 for both; prog write to 0x1000 leaves every word unchanged.
REQ-028 Stream 8 reads to 0x0..0x1C with resp_ready low for cycles 3-5 -> req_ready=0 while stalled, outputs stable, all 8 responses in order, none lost or duplicated.
REQ-029 Same-cycle prog write 0xDEADBEEF to 0x8 with read of 0x8 -> old value returned; next read of 0x8 returns 0xDEADBEEF.
REQ-030 Assert reset with 2 reads in flight -> no response emitted, INIT restarts, and a previously written word reads 0 after the second INIT.

Source files
------------

// File: rtl/pipelined_instr_mem.sv
// Instruction memory with a valid/ready fetch port and a fixed-depth read pipeline.
// A clear FSM zeroes the array after reset; a program-load port writes words in RUN.
module pipelined_instr_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_fault,
    input  logic                  prog_we,
    input  logic [31:0]           prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    output logic                  init_done
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int AW    = $clog2(MEM_DEPTH);
    localparam logic [32:0] LIMIT = 33'(MEM_DEPTH) * 33'(BYTES);
    localparam logic [31:0] AMASK = 32'(BYTES - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [LATENCY-1:0]    vld_q;
    logic [LATENCY-1:0]    flt_q;
    logic [DATA_WIDTH-1:0] dat_q [LATENCY];

    logic          run;
    logic          stall;
    logic          accept;
    logic          req_bad;
    logic          prog_bad;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] prog_idx;

    assign run      = (state_q == RUN);
    assign stall    = vld_q[LATENCY-1] & ~resp_ready;
    assign req_ready = reset & run & ~stall;
    assign accept   = req_valid & req_ready;

    assign req_bad  = (|(req_addr & AMASK)) || ({1'b0, req_addr} >= LIMIT);
    assign prog_bad = (|(prog_addr & AMASK)) || ({1'b0, prog_addr} >= LIMIT);
    assign req_idx  = req_addr[BSH +: AW];
    assign prog_idx = prog_addr[BSH +: AW];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(MEM_DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Writes land at the edge, so a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (!run) begin
                mem[cnt_q] <= '0;
            end else if (prog_we && !prog_bad) begin
                mem[prog_idx] <= prog_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q <= '0;
            flt_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else if (!stall) begin
            vld_q[0] <= accept;
            flt_q[0] <= accept & req_bad;
            dat_q[0] <= (accept && !req_bad) ? mem[req_idx] : '0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                flt_q[i] <= flt_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign resp_valid = reset & vld_q[LATENCY-1];
    assign resp_fault = reset & flt_q[LATENCY-1];
    assign resp_data  = reset ? dat_q[LATENCY-1] : '0;
    assign init_done  = reset & run;
endmodule

// File: tb/tb_pipelined_instr_mem.sv
// Directed bench for pipelined_instr_mem: a LATENCY=1 and a LATENCY=3 instance
// share stimulus; vectors cover clear, program load, faults, stalls and reset.
module tb_pipelined_instr_mem;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        resp_ready = 1'b1;
    logic        prog_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] prog_addr = '0;
    logic [31:0] prog_data = '0;

    logic        req_ready1, resp_valid1, resp_fault1, init_done1;
    logic [31:0] resp_data1;
    logic        req_ready3, resp_valid3, resp_fault3, init_done3;
    logic [31:0] resp_data3;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pipelined_instr_mem d1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready1), .req_addr(req_addr),
        .resp_valid(resp_valid1), .resp_ready(resp_ready),
        .resp_data(resp_data1), .resp_fault(resp_fault1),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .init_done(init_done1)
    );

    pipelined_instr_mem #(.LATENCY(3)) d3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready3), .req_addr(req_addr),
        .resp_valid(resp_valid3), .resp_ready(1'b1),
        .resp_data(resp_data3), .resp_fault(resp_fault3),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .init_done(init_done3)
    );

    typedef struct {
        logic        pwe;
        logic [31:0] paddr;
        logic [31:0] pdata;
        logic [31:0] raddr;
        logic [31:0] edata;
        logic        efault;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic pwe, input logic [31:0] pa,
                          input logic [31:0] pd, input logic [31:0] ra,
                          input logic [31:0] ed, input logic ef,
                          input string nm);
        prog_we    = pwe;
        prog_addr  = pa;
        prog_data  = pd;
        req_valid  = 1'b1;
        req_addr   = ra;
        resp_ready = 1'b1;
        #1;
        chk({nm, "_ready"}, 32'(req_ready1), 32'd1);
        step();
        prog_we   = 1'b0;
        req_valid = 1'b0;
        #1;
        chk({nm, "_valid"}, 32'(resp_valid1), 32'd1);
        chk({nm, "_data"}, resp_data1, ed);
        chk({nm, "_fault"}, 32'(resp_fault1), 32'(ef));
        step();
        #1;
        chk({nm, "_drop"}, 32'(resp_valid1), 32'd0);
    endtask

    task automatic wait_init(output int n, output int spur);
        n    = 0;
        spur = 0;
        while (!req_ready1 && n < 2000) begin
            n++;
            if (resp_valid1 || resp_valid3) spur++;
            step();
            #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          n;
        int          spur;
        int          issued;
        int          got;
        logic        stall;
        logic        prev_stall;
        logic        acc;
        logic [31:0] prev_data;

        vecs[0]  = '{1'b1, 32'h4,    32'h00500093, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h0,    32'h0,        32'h4,        32'h00500093, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,    32'h0,        32'h6,        32'h0,        1'b1};
        vecs[3]  = '{1'b0, 32'h0,    32'h0,        32'h1000,     32'h0,        1'b1};
        vecs[4]  = '{1'b1, 32'h1000, 32'h12345678, 32'hFFC,      32'h0,        1'b0};
        vecs[5]  = '{1'b1, 32'h8,    32'hDEADBEEF, 32'h8,        32'h0,        1'b0};
        vecs[6]  = '{1'b0, 32'h0,    32'h0,        32'h8,        32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b1, 32'hFFC,  32'hCAFEF00D, 32'h0,        32'h0,        1'b0};
        vecs[8]  = '{1'b0, 32'h0,    32'h0,        32'hFFC,      32'hCAFEF00D, 1'b0};
        vecs[9]  = '{1'b1, 32'h2,    32'h11111111, 32'h0,        32'h0,        1'b0};
        vecs[10] = '{1'b0, 32'h0,    32'h0,        32'h4,        32'h00500093, 1'b0};
        vecs[11] = '{1'b0, 32'h0,    32'h0,        32'hFFFFFFFC, 32'h0,        1'b1};

        reset     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        repeat (3) step();
        #1;
        chk("rst_resp_valid", 32'(resp_valid1), 32'd0);
        chk("rst_req_ready", 32'(req_ready1), 32'd0);
        chk("rst_init_done", 32'(init_done1), 32'd0);
        chk("rst_resp_data", resp_data1, 32'h0);
        chk("rst_resp_fault", 32'(resp_fault1), 32'd0);
        chk("rst_resp_valid3", 32'(resp_valid3), 32'd0);

        reset = 1'b1;
        #1;
        wait_init(n, spur);
        chk("init_cycles", 32'(n), 32'd1024);
        chk("init_spurious", 32'(spur), 32'd0);
        chk("init_done1", 32'(init_done1), 32'd1);
        chk("init_done3", 32'(init_done3), 32'd1);
        step();
        req_valid = 1'b0;
        #1;
        chk("first_valid", 32'(resp_valid1), 32'd1);
        chk("first_data", resp_data1, 32'h0);
        chk("first_fault", 32'(resp_fault1), 32'd0);
        step();

        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].pwe, vecs[i].paddr, vecs[i].pdata, vecs[i].raddr,
                   vecs[i].edata, vecs[i].efault, $sformatf("vec%0d", i));
        end

        repeat (4) step();
        req_valid = 1'b1;
        req_addr  = 32'h4;
        step();
        req_valid = 1'b0;
        #1;
        chk("lat1_valid", 32'(resp_valid1), 32'd1);
        chk("lat1_data", resp_data1, 32'h00500093);
        chk("lat3_c1", 32'(resp_valid3), 32'd0);
        step();
        #1;
        chk("lat3_c2", 32'(resp_valid3), 32'd0);
        step();
        #1;
        chk("lat3_valid", 32'(resp_valid3), 32'd1);
        chk("lat3_data", resp_data3, 32'h00500093);
        step();

        for (int i = 0; i < 8; i++) begin
            prog_we   = 1'b1;
            prog_addr = 32'(i * 4);
            prog_data = 32'hA0000000 + 32'(i);
            step();
        end
        prog_we    = 1'b0;
        issued     = 0;
        got        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cy = 0; cy < 40; cy++) begin
            req_valid  = (issued < 8);
            req_addr   = 32'(issued * 4);
            resp_ready = !(cy >= 3 && cy <= 5);
            #1;
            stall = resp_valid1 && !resp_ready;
            if (stall) chk("stall_ready", 32'(req_ready1), 32'd0);
            if (prev_stall) begin
                chk("stall_valid", 32'(resp_valid1), 32'd1);
                chk("stall_data", resp_data1, prev_data);
            end
            if (resp_valid1 && resp_ready) begin
                chk($sformatf("stream%0d", got), resp_data1,
                    32'hA0000000 + 32'(got));
                got++;
            end
            acc        = req_valid && req_ready1;
            prev_stall = stall;
            prev_data  = resp_data1;
            step();
            if (acc) issued++;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        chk("stream_issued", 32'(issued), 32'd8);
        chk("stream_got", 32'(got), 32'd8);

        repeat (2) step();
        req_valid = 1'b1;
        req_addr  = 32'h8;
        step();
        req_addr = 32'h4;
        step();
        reset     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rst2_valid1", 32'(resp_valid1), 32'd0);
        chk("rst2_valid3", 32'(resp_valid3), 32'd0);
        chk("rst2_ready", 32'(req_ready1), 32'd0);
        step();
        step();
        reset = 1'b1;
        #1;
        wait_init(n, spur);
        chk("reinit_cycles", 32'(n), 32'd1024);
        chk("reinit_spurious", 32'(spur), 32'd0);
        do_req(1'b0, 32'h0, 32'h0, 32'h8, 32'h0, 1'b0, "clr8");
        do_req(1'b0, 32'h0, 32'h0, 32'hFFC, 32'h0, 1'b0, "clrFFC");
        do_req(1'b0, 32'h0, 32'h0, 32'h4, 32'h0, 1'b0, "clr4");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
